c2h_stream_serializer: RTL and testbench

- Downstream neighbour of the packet-capture stage on the C2H path.
- Takes one 4072-bit captured packet per data_valid pulse. That packet is 4064 bits of trace data above an 8-bit sequence number in bits [7:0].
- Slices the packet into 512-bit AXI4-Stream beats for the XDMA C2H channel 0.
- Pulses data_next back upstream once the whole packet has been accepted, so the capture stage can arm for the next packet.

---
 rtl/c2h_stream_serializer.sv | 146 ++++++++++++++
 tb/tb_c2h_stream_serializer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2h_stream_serializer.sv
// Slices one captured packet into BEAT_W-bit AXI4-Stream beats for XDMA C2H channel 0.
// Optional build macro C2H_SEQ_CHECK_EN adds a sticky sequence-number continuity flag (seq_err).
module c2h_stream_serializer #(
    parameter int IN_W   = 4072,
    parameter int BEAT_W = 512,
    parameter int BEATS  = 8
) (
    input  logic                m_axis_c2h_aclk,
    input  logic                m_axis_c2h_areset,
    input  logic [IN_W-1:0]     in_data,
    input  logic                in_valid,
    output logic                data_next,
    output logic                busy,
    output logic [BEAT_W-1:0]   m_axis_c2h_tdata_0,
    output logic [BEAT_W/8-1:0] m_axis_c2h_tkeep_0,
    output logic                m_axis_c2h_tvalid_0,
    output logic                m_axis_c2h_tlast_0,
    input  logic                m_axis_c2h_tready_0,
    output logic [1:0]          dbg_state,
    output logic [7:0]          drop_cnt
`ifdef C2H_SEQ_CHECK_EN
    ,
    output logic                seq_err
`endif
);

    // Handshake: a beat transfers on a clock edge where tvalid and tready are both high;
    // tvalid comes straight from the state register and is held until that edge.
    localparam int KEEP_W     = BEAT_W / 8;
    localparam int PKT_W      = BEATS * BEAT_W;
    localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_BYTES = IN_W / 8 - (BEATS - 1) * KEEP_W;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BEATS - 1);
    localparam logic [KEEP_W-1:0] LAST_KEEP = {KEEP_W{1'b1}} >> (KEEP_W - LAST_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic               hs;
    logic               last_hs;
    logic [IDX_W-1:0]   beat_idx;
    logic [IDX_W-1:0]   next_idx;
    logic [PKT_W-1:0]   pkt_q;
    logic [PKT_W-1:0]   pkt_in;
    logic [BEAT_W-1:0]  tdata_q;
    logic [KEEP_W-1:0]  tkeep_q;
    logic               tlast_q;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        hs       = 1'b0;
        last_hs  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                hs = m_axis_c2h_tready_0;
                if (hs && beat_idx == LAST_IDX) begin
                    last_hs  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Upper pad bits of the packet register are always zero.
    always_comb begin
        pkt_in             = '0;
        pkt_in[IN_W-1:0]   = in_data;
    end

    assign next_idx = beat_idx + IDX_W'(1);

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (m_axis_c2h_areset) begin
            state    <= IDLE;
            beat_idx <= '0;
            pkt_q    <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                pkt_q    <= pkt_in;
                beat_idx <= '0;
                tdata_q  <= pkt_in[BEAT_W-1:0];
                tkeep_q  <= (BEATS == 1) ? LAST_KEEP : {KEEP_W{1'b1}};
                tlast_q  <= (BEATS == 1);
            end else if (hs && !last_hs) begin
                // Index and its beat data advance on the same edge: one beat per clock.
                beat_idx <= next_idx;
                tdata_q  <= pkt_q[int'(next_idx) * BEAT_W +: BEAT_W];
                tkeep_q  <= (next_idx == LAST_IDX) ? LAST_KEEP : {KEEP_W{1'b1}};
                tlast_q  <= (next_idx == LAST_IDX);
            end else if (last_hs) begin
                tkeep_q <= '0;
                tlast_q <= 1'b0;
            end
            if (in_valid && state != IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign m_axis_c2h_tvalid_0 = (state == SEND);
    assign m_axis_c2h_tdata_0  = tdata_q;
    assign m_axis_c2h_tkeep_0  = tkeep_q;
    assign m_axis_c2h_tlast_0  = tlast_q;
    assign busy                = (state != IDLE);
    assign data_next           = (state == DONE);
    assign dbg_state           = state;

`ifdef C2H_SEQ_CHECK_EN
    logic       have_prev;
    logic [7:0] prev_seq;

    // The first packet after reset only seeds prev_seq.
    always_ff @(posedge m_axis_c2h_aclk) begin
        if (m_axis_c2h_areset) begin
            have_prev <= 1'b0;
            prev_seq  <= 8'd0;
            seq_err   <= 1'b0;
        end else if (accept) begin
            have_prev <= 1'b1;
            prev_seq  <= in_data[7:0];
            if (have_prev && in_data[7:0] != prev_seq + 8'd1)
                seq_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_c2h_stream_serializer.sv
// Directed bench for c2h_stream_serializer: beat scoreboard, stall stability, overrun and reset cases.
module tb_c2h_stream_serializer;

    localparam int IN_W   = 4072;
    localparam int BEAT_W = 512;
    localparam int CW     = 600;
    localparam logic [63:0] LAST_KEEP_EXP = 64'h1FFF_FFFF_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic [IN_W-1:0]   in_data = '0;
    logic              in_valid = 1'b0;
    logic              data_next;
    logic              busy;
    logic [BEAT_W-1:0] tdata;
    logic [63:0]       tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready = 1'b0;
    logic [1:0]        dbg_state;
    logic [7:0]        drop_cnt;
`ifdef C2H_SEQ_CHECK_EN
    logic              seq_err;
`endif

    always #5 clk = ~clk;

    c2h_stream_serializer dut (
        .m_axis_c2h_aclk     (clk),
        .m_axis_c2h_areset   (areset),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .data_next           (data_next),
        .busy                (busy),
        .m_axis_c2h_tdata_0  (tdata),
        .m_axis_c2h_tkeep_0  (tkeep),
        .m_axis_c2h_tvalid_0 (tvalid),
        .m_axis_c2h_tlast_0  (tlast),
        .m_axis_c2h_tready_0 (tready),
        .dbg_state           (dbg_state),
        .drop_cnt            (drop_cnt)
`ifdef C2H_SEQ_CHECK_EN
        ,
        .seq_err             (seq_err)
`endif
    );

    logic [577:0] exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           hs_cnt = 0;
    int           dn_cnt = 0;
    logic         stall_prev = 1'b0;
    logic [577:0] stall_val = '0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor on the falling edge: pops the scoreboard per handshake, checks stall hold.
    always @(negedge clk) begin
        if (areset) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", CW'({tvalid, tlast, tkeep, tdata}), CW'(stall_val));
            if (tlast)
                chk("tlast_needs_tvalid", CW'(tvalid), CW'(1));
            if (data_next)
                dn_cnt <= dn_cnt + 1;
            if (tvalid && tready) begin
                hs_cnt <= hs_cnt + 1;
                chk("beat_expected", CW'(exp_q.size() != 0), CW'(1));
                if (exp_q.size() != 0)
                    chk("beat", CW'({tvalid, tlast, tkeep, tdata}), CW'(exp_q.pop_front()));
            end
            stall_prev <= tvalid && !tready;
            stall_val  <= {tvalid, tlast, tkeep, tdata};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] make_pkt(input logic [7:0] seq);
        logic [4095:0] t;
        for (int i = 0; i < 128; i++) t[i*32 +: 32] = $urandom;
        t[7:0] = seq;
        return t[IN_W-1:0];
    endfunction

    task automatic push_exp(input logic [IN_W-1:0] p);
        logic [4095:0] pad;
        pad = '0;
        pad[IN_W-1:0] = p;
        for (int k = 0; k < 8; k++)
            exp_q.push_back({1'b1, (k == 7), (k == 7) ? LAST_KEEP_EXP : {64{1'b1}}, pad[k*512 +: 512]});
    endtask

    task automatic capture(input logic [IN_W-1:0] p, input bit expect_accept);
        in_data  = p;
        in_valid = 1'b1;
        if (expect_accept) push_exp(p);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (data_next !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(tag, CW'(data_next), CW'(1));
    endtask

    task automatic do_reset();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
        exp_q.delete();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [IN_W-1:0] p;
        logic [IN_W-1:0] p2;
        logic [3:0]      pat;
        int              hs0;
        int              dn0;
        int              n;

        // Reset state
        areset = 1'b1;
        step();
        step();
        chk("rst_tvalid", CW'(tvalid), CW'(0));
        chk("rst_busy", CW'(busy), CW'(0));
        chk("rst_data_next", CW'(data_next), CW'(0));
        chk("rst_tkeep", CW'(tkeep), CW'(0));
        chk("rst_tlast", CW'(tlast), CW'(0));
        chk("rst_drop", CW'(drop_cnt), CW'(0));
        chk("rst_state", CW'(dbg_state), CW'(0));
        areset = 1'b0;
        step();

        // Packet seq 05, tready held high: exact 10-clock timing
        tready = 1'b1;
        p   = make_pkt(8'h05);
        hs0 = hs_cnt;
        dn0 = dn_cnt;
        capture(p, 1'b1);
        chk("a_lat_tvalid", CW'(tvalid), CW'(1));
        chk("a_beat0_seq", CW'(tdata[7:0]), CW'(8'h05));
        chk("a_beat0_tlast", CW'(tlast), CW'(0));
        chk("a_beat0_tkeep", CW'(tkeep), CW'({64{1'b1}}));
        chk("a_busy", CW'(busy), CW'(1));
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("a_tvalid_run", CW'(tvalid), CW'(1));
            chk("a_no_data_next", CW'(data_next), CW'(0));
        end
        chk("a_beat7_tlast", CW'(tlast), CW'(1));
        chk("a_beat7_tkeep", CW'(tkeep), CW'(LAST_KEEP_EXP));
        step();
        chk("a_done_data_next", CW'(data_next), CW'(1));
        chk("a_done_tvalid", CW'(tvalid), CW'(0));
        chk("a_done_busy", CW'(busy), CW'(1));
        step();
        chk("a_idle_data_next", CW'(data_next), CW'(0));
        chk("a_idle_busy", CW'(busy), CW'(0));
        chk("a_hs_count", CW'(hs_cnt - hs0), CW'(8));
        chk("a_dn_count", CW'(dn_cnt - dn0), CW'(1));
        chk("a_queue_empty", CW'(exp_q.size()), CW'(0));

        // Same packet, tready pattern 1,0,0,1 repeating
        hs0 = hs_cnt;
        dn0 = dn_cnt;
        pat = 4'b1001;
        capture(p, 1'b1);
        n = 0;
        while (data_next !== 1'b1 && n < 80) begin
            tready = pat[n % 4];
            step();
            n++;
        end
        chk("b_done", CW'(data_next), CW'(1));
        tready = 1'b1;
        step();
        step();
        chk("b_hs_count", CW'(hs_cnt - hs0), CW'(8));
        chk("b_dn_count", CW'(dn_cnt - dn0), CW'(1));
        chk("b_queue_empty", CW'(exp_q.size()), CW'(0));

        // Second in_valid three clocks into SEND is dropped
        do_reset();
        tready = 1'b1;
        p  = make_pkt(8'h10);
        p2 = make_pkt(8'h11);
        capture(p, 1'b1);
        step();
        step();
        capture(p2, 1'b0);
        wait_done("c_done", 20);
        step();
        chk("c_drop", CW'(drop_cnt), CW'(1));
        chk("c_queue_empty", CW'(exp_q.size()), CW'(0));

        // in_valid during DONE is dropped too
        do_reset();
        tready = 1'b1;
        p  = make_pkt(8'h20);
        p2 = make_pkt(8'h21);
        capture(p, 1'b1);
        wait_done("f_done", 20);
        capture(p2, 1'b0);
        chk("f_idle_busy", CW'(busy), CW'(0));
        chk("f_drop", CW'(drop_cnt), CW'(1));
        step();
        chk("f_no_restart", CW'(tvalid), CW'(0));

        // 300 pulses while stalled: drop_cnt saturates, first packet still completes
        do_reset();
        tready = 1'b0;
        p = make_pkt(8'h30);
        capture(p, 1'b1);
        in_data  = make_pkt(8'h99);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        chk("d_drop_sat", CW'(drop_cnt), CW'(255));
        chk("d_tvalid_held", CW'(tvalid), CW'(1));
        tready = 1'b1;
        wait_done("d_done", 20);
        step();
        chk("d_queue_empty", CW'(exp_q.size()), CW'(0));
        chk("d_drop_after", CW'(drop_cnt), CW'(255));

        // Reset mid-packet on beat 4 with tready low
        do_reset();
        tready = 1'b1;
        p = make_pkt(8'h40);
        capture(p, 1'b1);
        for (int i = 0; i < 4; i++) step();
        tready = 1'b0;
        capture(make_pkt(8'h41), 1'b0);
        chk("e_stalled_tvalid", CW'(tvalid), CW'(1));
        chk("e_drop_before", CW'(drop_cnt), CW'(1));
        dn0 = dn_cnt;
        areset = 1'b1;
        step();
        chk("e_rst_tvalid", CW'(tvalid), CW'(0));
        chk("e_rst_busy", CW'(busy), CW'(0));
        chk("e_rst_drop", CW'(drop_cnt), CW'(0));
        chk("e_rst_tlast", CW'(tlast), CW'(0));
        chk("e_rst_data_next", CW'(data_next), CW'(0));
        chk("e_rst_tkeep", CW'(tkeep), CW'(0));
        areset = 1'b0;
        exp_q.delete();
        step();
        step();
        chk("e_no_data_next", CW'(dn_cnt - dn0), CW'(0));
        chk("e_idle_tvalid", CW'(tvalid), CW'(0));
        tready = 1'b1;
        p = make_pkt(8'h42);
        capture(p, 1'b1);
        chk("e_new_beat0", CW'(tdata[7:0]), CW'(8'h42));
        wait_done("e_done", 20);
        step();
        chk("e_queue_empty", CW'(exp_q.size()), CW'(0));

`ifdef C2H_SEQ_CHECK_EN
        // Sequence continuity across wraparound, then a gap
        do_reset();
        tready = 1'b1;
        chk("s_rst", CW'(seq_err), CW'(0));
        capture(make_pkt(8'hFE), 1'b1);
        wait_done("s_done_fe", 20);
        step();
        capture(make_pkt(8'hFF), 1'b1);
        wait_done("s_done_ff", 20);
        step();
        capture(make_pkt(8'h00), 1'b1);
        wait_done("s_done_00", 20);
        step();
        chk("s_wrap_ok", CW'(seq_err), CW'(0));
        capture(make_pkt(8'h02), 1'b1);
        chk("s_gap_err", CW'(seq_err), CW'(1));
        wait_done("s_done_02", 20);
        step();
        capture(make_pkt(8'h03), 1'b1);
        wait_done("s_done_03", 20);
        step();
        chk("s_sticky", CW'(seq_err), CW'(1));
        do_reset();
        chk("s_cleared", CW'(seq_err), CW'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
